// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared FSM state type and keep-clamp helper for stream width converters
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Word count actually carried by a beat: keep values above the beat capacity saturate.
    function automatic int unsigned clamp_keep(input int unsigned keep, input int unsigned ratio);
        return (keep > ratio) ? ratio : keep;
    endfunction

endpackage

// File: rtl/stream_beat_reg.sv
// rtl/stream_beat_reg.sv - wide beat holding register with load enable
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture d_data/d_last on the rising edge
//   d_data, d_last    incoming wide beat and its end-of-packet flag
//   q_data, q_last    held wide beat and its end-of-packet flag
module stream_beat_reg #(
    parameter int T_DATA_WIDTH = 32,
    parameter int T_DATA_RATIO = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [T_DATA_WIDTH-1:0] d_data [T_DATA_RATIO-1:0],
    input  logic                    d_last,
    output logic [T_DATA_WIDTH-1:0] q_data [T_DATA_RATIO-1:0],
    output logic                    q_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                q_data[i] <= '0;
            end
            q_last <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                q_data[i] <= d_data[i];
            end
            q_last <= d_last;
        end
    end

endmodule

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - splits wide multi-word beats into a narrow word stream
//
// Optional feature: STREAM_UNPACKER_PREFETCH_EN (zero-bubble beat-to-beat operation).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_data, s_keep, s_last  wide beat (index 0 oldest), valid word count, end of packet
//   s_valid, s_ready        wide-side handshake
//   m_data, m_last          narrow word and end of packet
//   m_valid, m_ready        narrow-side handshake
//   err_keep                sticky flag, set by an accepted beat with s_keep == 0
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH = 32,
    parameter int T_DATA_RATIO = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [T_DATA_WIDTH-1:0]       s_data [T_DATA_RATIO-1:0],
    input  logic [$clog2(T_DATA_RATIO):0] s_keep,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [T_DATA_WIDTH-1:0]       m_data,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          err_keep
);

    localparam int T_WIDTH_RATIO = $clog2(T_DATA_RATIO);
    localparam int CW            = T_WIDTH_RATIO + 1;

    state_t                    state, state_next;
    logic [T_WIDTH_RATIO-1:0]  idx, idx_next;
    logic [CW-1:0]             count, count_next;
    logic                      err_next;
    logic                      load;
    logic                      s_hs, m_hs;
    logic                      final_word;
    logic [T_DATA_WIDTH-1:0]   held [T_DATA_RATIO-1:0];
    logic                      held_last;

    stream_beat_reg #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_beat_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .d_data (s_data),
        .d_last (s_last),
        .q_data (held),
        .q_last (held_last)
    );

    // Outputs come only from registers, so m_valid never sees s_valid combinationally.
    assign final_word = (state == SEND) && ({1'b0, idx} == count - 1'b1);
    assign m_valid    = (state == SEND);
    assign m_data     = held[idx];
    assign m_last     = final_word && held_last;

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid && m_ready;

`ifdef STREAM_UNPACKER_PREFETCH_EN
    // Keeps s_ready low during reset and until the first edge after release.
    logic alive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    // A new beat may land in the same edge that retires the final word.
    assign s_ready = alive && ((state == IDLE) || (final_word && m_ready));
`else
    // Registered copy of "next state is IDLE": equals state==IDLE without any path from m_ready.
    logic ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_next == IDLE);
        end
    end

    assign s_ready = ready_q;
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        count_next = count;
        err_next   = err_keep;
        load       = 1'b0;

        if (m_hs) begin
            if (final_word) begin
                state_next = IDLE;
            end else begin
                idx_next = idx + 1'b1;
            end
        end

        // A beat accepted alongside the final word overrides the return to IDLE.
        if (s_hs) begin
            if (s_keep != '0) begin
                load       = 1'b1;
                state_next = SEND;
                idx_next   = '0;
                count_next = CW'(clamp_keep(32'(s_keep), T_DATA_RATIO));
            end else begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            count    <= '0;
            err_keep <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            count    <= count_next;
            err_keep <= err_next;
        end
    end

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - randomized and directed self-checking bench for stream_unpacker
module tb_stream_unpacker;

    localparam int W  = 32;
    localparam int R  = 3;
    localparam int KW = $clog2(R) + 1;

    typedef struct {
        logic [W-1:0] d [R-1:0];
        int           keep;
        bit           last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  s_data [R-1:0];
    logic [KW-1:0] s_keep;
    logic          s_last, s_valid, s_ready;
    logic [W-1:0]  m_data;
    logic          m_last, m_valid, m_ready, err_keep;

    stream_unpacker #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_keep   (s_keep),
        .s_last   (s_last),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_keep (err_keep)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W:0]   expq [$];
    beat_t        pend [$];
    bit           rdy_pat [$];
    int           hs_cyc [$];
    int           acc_cyc [$];
    bit           exp_err = 0;
    bit           rnd_ready = 0;
    int           cyc = 0;
    bit           stall_pending = 0;
    logic [W-1:0] stall_d;
    logic         stall_l;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int keep, input bit last, input int unsigned a,
                                 input int unsigned b, input int unsigned c);
        beat_t x;
        x.d[0] = a; x.d[1] = b; x.d[2] = c;
        x.keep = keep;
        x.last = last;
        return x;
    endfunction

    // Reference: an accepted beat contributes min(keep,R) words in index order,
    // the final one flagged last when the beat ends a packet; keep==0 contributes nothing.
    task automatic model_accept();
        int k;
        k = (int'(s_keep) > R) ? R : int'(s_keep);
        for (int i = 0; i < k; i++) begin
            expq.push_back({(s_last && (i == k - 1)), s_data[i]});
        end
        if (s_keep == 0) exp_err = 1'b1;
    endtask

    task automatic step();
        bit        acc;
        logic [W:0] e;
        beat_t     b;
        @(negedge clk);
        cyc++;
        if (stall_pending) begin
            check("stall_valid", m_valid, 1);
            check("stall_data", m_data, stall_d);
            check("stall_last", m_last, stall_l);
            stall_pending = 0;
        end
        if (m_valid && !m_ready) begin
            stall_pending = 1;
            stall_d = m_data;
            stall_l = m_last;
        end
        check("err_keep", err_keep, exp_err);
        if (m_valid && m_ready) begin
            hs_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                check("unexpected_word", m_valid, 0);
            end else begin
                e = expq.pop_front();
                check("m_data", m_data, e[W-1:0]);
                check("m_last", m_last, e[W]);
            end
        end
        acc = s_valid && s_ready;
        if (acc) begin
            acc_cyc.push_back(cyc);
            model_accept();
        end
        @(posedge clk);
        #1;
        if (acc) s_valid = 0;
        if (!s_valid && pend.size() > 0) begin
            b = pend.pop_front();
            for (int i = 0; i < R; i++) s_data[i] = b.d[i];
            s_keep  = KW'(b.keep);
            s_last  = b.last;
            s_valid = 1;
        end else if (!s_valid) begin
            for (int i = 0; i < R; i++) s_data[i] = $urandom;
            s_keep = KW'($urandom_range(0, 7));
            s_last = 1'($urandom_range(0, 1));
        end
        if (rdy_pat.size() > 0) m_ready = rdy_pat.pop_front();
        else if (rnd_ready)     m_ready = 1'($urandom_range(0, 1));
        else                    m_ready = 1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((pend.size() > 0 || s_valid || expq.size() > 0 || m_valid) && n < maxc) begin
            step();
            n++;
        end
        check("drain_timeout", n < maxc, 1);
        check("leftover_words", expq.size(), 0);
    endtask

    task automatic clear_log();
        hs_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int n;
        rst_n   = 0;
        s_valid = 0;
        m_ready = 0;
        s_last  = 0;
        s_keep  = '0;
        for (int i = 0; i < R; i++) s_data[i] = '0;
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_err_keep", err_keep, 0);
        check("rst_s_ready", s_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rel_s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("rel_s_ready_after_edge", s_ready, 1);

        // Three words in order, one-cycle first-word latency, last only on the third.
        clear_log();
        pend.push_back(mk(3, 1, 1, 2, 3));
        step();
        drain(50);
        check("s032_words", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3 && acc_cyc.size() == 1) begin
            check("s032_latency", hs_cyc[0] - acc_cyc[0], 1);
            check("s032_consec1", hs_cyc[1] - hs_cyc[0], 1);
            check("s032_consec2", hs_cyc[2] - hs_cyc[1], 1);
        end

        // Back-to-back beats: gap between the final word of beat 1 and word 0 of beat 2.
        clear_log();
        pend.push_back(mk(2, 0, 32'haa, 32'hbb, 32'h0));
        pend.push_back(mk(1, 1, 32'hcc, 32'h0, 32'h0));
        step();
        drain(50);
        check("s033_words", hs_cyc.size(), 3);
        if (hs_cyc.size() == 3) begin
            check("s033_ab_gap", hs_cyc[1] - hs_cyc[0], 1);
`ifdef STREAM_UNPACKER_PREFETCH_EN
            check("s033_bc_gap", hs_cyc[2] - hs_cyc[1], 1);
`else
            check("s033_bc_gap", hs_cyc[2] - hs_cyc[1], 2);
`endif
        end

        // Consumer stalls on word 1 for two cycles.
        clear_log();
        rdy_pat = '{1, 1, 0, 0, 1, 1, 1};
        pend.push_back(mk(3, 1, 32'h11, 32'h22, 32'h33));
        step();
        drain(50);
        check("s034_words", hs_cyc.size(), 3);

        // Oversized keep clamps to capacity with no error.
        clear_log();
        pend.push_back(mk(7, 1, 32'h71, 32'h72, 32'h73));
        step();
        drain(50);
        check("s036_words", hs_cyc.size(), 3);
        check("s036_err", err_keep, 0);

        // keep==0 beat is swallowed and flags the sticky error.
        clear_log();
        pend.push_back(mk(0, 1, 32'hdead, 32'hbeef, 32'h0));
        pend.push_back(mk(1, 1, 32'h5, 32'h0, 32'h0));
        step();
        drain(50);
        check("s035_words", hs_cyc.size(), 1);
        check("s035_err", err_keep, 1);

        // Random traffic with random backpressure.
        rnd_ready = 1;
        for (int i = 0; i < 200; i++) begin
            pend.push_back(mk($urandom_range(0, 7), 1'($urandom_range(0, 1)),
                              $urandom, $urandom, $urandom));
        end
        step();
        drain(5000);
        rnd_ready = 0;

        // Reset in the middle of a beat after word 1.
        clear_log();
        pend.push_back(mk(3, 1, 32'h91, 32'h92, 32'h93));
        n = 0;
        while (hs_cyc.size() < 2 && n < 50) begin
            step();
            n++;
        end
        check("s037_reach_word1", n < 50, 1);
        #2;
        rst_n = 0;
        #1;
        check("s037_m_valid_async", m_valid, 0);
        check("s037_m_last_async", m_last, 0);
        check("s037_s_ready_async", s_ready, 0);
        check("s037_err_cleared", err_keep, 0);
        expq.delete();
        pend.delete();
        s_valid = 0;
        exp_err = 0;
        stall_pending = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("s037_s_ready_before_edge", s_ready, 0);
        @(posedge clk);
        #1;
        check("s037_s_ready_after_edge", s_ready, 1);
        clear_log();
        repeat (5) step();
        check("s037_no_more_words", hs_cyc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
